// File: rtl/db_chroma_edge_ctrl_if.sv
// Command, pixel-buffer and filter signals of the chroma edge sequencer, bundled for its neighbours.
// master = the sequencer; slave = scheduler / buffer / filter side.
interface db_chroma_edge_ctrl_if #(
    parameter int AW = 10
);
    logic          seg_valid_i;
    logic          seg_ready_o;
    logic [AW-1:0] seg_addr_i;
    logic [5:0]    seg_qp_p_i;
    logic [5:0]    seg_qp_q_i;
    logic [1:0]    seg_bs_i;
    logic [4:0]    cqp_offset_i;
    logic [3:0]    tc_offset_div2_i;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [31:0]   rd_data_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [31:0]   wr_data_o;
    logic [4:0]    flt_tc_o;
    logic [31:0]   flt_p0_o;
    logic [31:0]   flt_p1_o;
    logic [31:0]   flt_q0_o;
    logic [31:0]   flt_q1_o;
    logic [31:0]   flt_p0_i;
    logic [31:0]   flt_q0_i;
    logic          done_o;

    modport master (
        input  seg_valid_i, seg_addr_i, seg_qp_p_i, seg_qp_q_i, seg_bs_i,
               cqp_offset_i, tc_offset_div2_i, rd_data_i, flt_p0_i, flt_q0_i,
        output seg_ready_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
               flt_tc_o, flt_p0_o, flt_p1_o, flt_q0_o, flt_q1_o, done_o
    );

    modport slave (
        output seg_valid_i, seg_addr_i, seg_qp_p_i, seg_qp_q_i, seg_bs_i,
               cqp_offset_i, tc_offset_div2_i, rd_data_i, flt_p0_i, flt_q0_i,
        input  seg_ready_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o,
               flt_tc_o, flt_p0_o, flt_p1_o, flt_q0_o, flt_q1_o, done_o
    );
endinterface

// File: rtl/db_chroma_edge_ctrl.sv
// Chroma edge sequencer: derives tc, reads 4 lines of p1/p0/q0/q1, runs the filter, writes p0/q0 back.
// Latency 10 cycles accept-to-done (1 when skipped); seg_ready_o low while busy, command held until taken.
module db_chroma_edge_ctrl #(
    parameter int AW        = 10,
    parameter int LINE_STEP = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    db_chroma_edge_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD, RWAIT, FLT, WR} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [4:0]      tc_q, tc_d;
    logic [3:0][31:0] line_q, line_d;
    logic            rd_vld_q, rd_vld_d;
    logic [1:0]      rd_idx_q, rd_idx_d;
    logic            skip_done_q, skip_done_d;

    logic            accept, skip;
    logic [7:0]      qp_avg;
    logic signed [7:0] qpi_raw, q_raw;
    logic [5:0]      qpi, qpc, q_idx;
    logic [4:0]      tc_calc;
    logic [AW-1:0]   line_addr;

    function automatic logic [5:0] chroma_qp(input logic [5:0] qi);
        logic [5:0] r;
        r = qi;
        if (qi > 6'd43) begin
            r = qi - 6'd6;
        end else if (qi >= 6'd30) begin
            case (qi)
                6'd30:        r = 6'd29;
                6'd31:        r = 6'd30;
                6'd32:        r = 6'd31;
                6'd33:        r = 6'd32;
                6'd34, 6'd35: r = 6'd33;
                6'd36, 6'd37: r = 6'd34;
                6'd38, 6'd39: r = 6'd35;
                6'd40, 6'd41: r = 6'd36;
                default:      r = 6'd37;
            endcase
        end
        return r;
    endfunction

    function automatic logic [4:0] tc_lut(input logic [5:0] qv);
        logic [4:0] r;
        if      (qv < 6'd18) r = 5'd0;
        else if (qv < 6'd27) r = 5'd1;
        else if (qv < 6'd31) r = 5'd2;
        else if (qv < 6'd35) r = 5'd3;
        else if (qv < 6'd38) r = 5'd4;
        else begin
            case (qv)
                6'd38, 6'd39: r = 5'd5;
                6'd40, 6'd41: r = 5'd6;
                6'd42:        r = 5'd7;
                6'd43:        r = 5'd8;
                6'd44:        r = 5'd9;
                6'd45:        r = 5'd10;
                6'd46:        r = 5'd11;
                6'd47:        r = 5'd13;
                6'd48:        r = 5'd14;
                6'd49:        r = 5'd16;
                6'd50:        r = 5'd18;
                6'd51:        r = 5'd20;
                6'd52:        r = 5'd22;
                default:      r = 5'd24;
            endcase
        end
        return r;
    endfunction

    // tc is computed straight from the command inputs so it can be captured on the accept edge.
    always_comb begin
        qp_avg  = ({2'b00, bus.seg_qp_p_i} + {2'b00, bus.seg_qp_q_i} + 8'd1) >> 1;
        qpi_raw = $signed(qp_avg) + $signed({{3{bus.cqp_offset_i[4]}}, bus.cqp_offset_i});
        if (qpi_raw < 8'sd0)       qpi = 6'd0;
        else if (qpi_raw > 8'sd51) qpi = 6'd51;
        else                       qpi = qpi_raw[5:0];
        qpc   = chroma_qp(qpi);
        q_raw = $signed({2'b00, qpc}) + 8'sd2
              + $signed({{3{bus.tc_offset_div2_i[3]}}, bus.tc_offset_div2_i, 1'b0});
        if (q_raw < 8'sd0)       q_idx = 6'd0;
        else if (q_raw > 8'sd53) q_idx = 6'd53;
        else                     q_idx = q_raw[5:0];
        tc_calc = tc_lut(q_idx);
    end

    assign accept    = bus.seg_valid_i && (state_q == IDLE);
    assign skip      = (bus.seg_bs_i != 2'd2) || (tc_calc == 5'd0);
    assign line_addr = addr_q + AW'(cnt_q) * AW'(LINE_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !skip) state_d = RD;
            RD:      if (cnt_q == 2'd3)   state_d = RWAIT;
            RWAIT:   state_d = FLT;
            FLT:     state_d = WR;
            WR:      if (cnt_q == 2'd3)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data lands one cycle after its strobe, so the line index travels with a valid flag.
    always_comb begin
        cnt_d       = (state_q == RD || state_q == WR) ? cnt_q + 2'd1 : 2'd0;
        addr_d      = accept ? bus.seg_addr_i : addr_q;
        tc_d        = accept ? tc_calc : tc_q;
        skip_done_d = accept && skip;
        rd_vld_d    = (state_q == RD);
        rd_idx_d    = cnt_q;
        line_d      = line_q;
        if (rd_vld_q) line_d[rd_idx_q] = bus.rd_data_i;
        if (state_q == FLT) begin
            for (int k = 0; k < 4; k++) begin
                line_d[k][15:8]  = bus.flt_p0_i[8*k +: 8];
                line_d[k][23:16] = bus.flt_q0_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            tc_q        <= '0;
            line_q      <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            skip_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            tc_q        <= tc_d;
            line_q      <= line_d;
            rd_vld_q    <= rd_vld_d;
            rd_idx_q    <= rd_idx_d;
            skip_done_q <= skip_done_d;
        end
    end

    logic        rd_en, wr_en, done;
    logic [31:0] p0_pk, p1_pk, q0_pk, q1_pk;

    always_comb begin
        rd_en = (state_q == RD);
        wr_en = (state_q == WR);
        done  = skip_done_q || (state_q == WR && cnt_q == 2'd3);
        p0_pk = '0;
        p1_pk = '0;
        q0_pk = '0;
        q1_pk = '0;
        for (int k = 0; k < 4; k++) begin
            p1_pk[8*k +: 8] = line_q[k][7:0];
            p0_pk[8*k +: 8] = line_q[k][15:8];
            q0_pk[8*k +: 8] = line_q[k][23:16];
            q1_pk[8*k +: 8] = line_q[k][31:24];
        end
    end

    assign bus.seg_ready_o = (state_q == IDLE);
    assign bus.rd_en_o     = rd_en;
    assign bus.rd_addr_o   = line_addr;
    assign bus.wr_en_o     = wr_en;
    assign bus.wr_addr_o   = line_addr;
    assign bus.wr_data_o   = line_q[cnt_q];
    assign bus.flt_tc_o    = tc_q;
    assign bus.flt_p0_o    = p0_pk;
    assign bus.flt_p1_o    = p1_pk;
    assign bus.flt_q0_o    = q0_pk;
    assign bus.flt_q1_o    = q1_pk;
    assign bus.done_o      = done;
endmodule
